// File: rtl/rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_ctrl
// Description : Read-side pointer controller for an asynchronous FIFO.
//               It holds the binary and Gray read pointers and drives the RAM
//               read address. It compares the next read pointer with the
//               write pointer that has already been synchronised into the
//               read domain. From that comparison it produces registered
//               empty, almost-empty, fill-count and sticky underflow status.
//
// Ports       : rclk          - read clock
//               rrst_n        - asynchronous active-low reset
//               rinc          - pop request; ignored while rempty=1
//               rclr_err      - synchronous clear of runderflow
//               rq2_wptr      - Gray write pointer, synchronised to rclk
//               raddr         - RAM read address (low bits of binary pointer)
//               rptr          - registered Gray read pointer to write domain
//               rempty        - registered empty flag
//               ralmost_empty - registered flag, fill count <= AE_THRESH
//               rcount        - registered read-side fill level
//               runderflow    - sticky flag, read attempted while empty
//
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rinc,
    input  logic                 rclr_err,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic                 ralmost_empty,
    output logic [ADDR_SIZE:0]   rcount,
    output logic                 runderflow
);

    localparam logic [ADDR_SIZE:0] c_AE_THRESH = AE_THRESH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] r_rbin;
    logic [ADDR_SIZE:0] r_rgray;
    logic               r_empty;
    logic               r_almost_empty;
    logic [ADDR_SIZE:0] r_count;
    logic               r_underflow;

    logic               w_rd_en;
    logic [ADDR_SIZE:0] w_rbin_next;
    logic [ADDR_SIZE:0] w_rgray_next;
    logic [ADDR_SIZE:0] w_wbin_s;
    logic [ADDR_SIZE:0] w_fill;

    // A pop only happens when the registered flag says data is present, so
    // the pointer can never run past the synchronised write pointer.
    assign w_rd_en      = rinc & ~r_empty;
    assign w_rbin_next  = r_rbin + {{ADDR_SIZE{1'b0}}, w_rd_en};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    // Gray-to-binary of the synchronised write pointer: each bit is the XOR
    // of itself and every more-significant Gray bit.
    assign w_wbin_s[ADDR_SIZE] = rq2_wptr[ADDR_SIZE];
    for (genvar gi = ADDR_SIZE - 1; gi >= 0; gi--) begin : g_g2b
        assign w_wbin_s[gi] = w_wbin_s[gi+1] ^ rq2_wptr[gi];
    end

    // Modulo subtraction yields 0..2**ADDR_SIZE because the MSB tracks lap.
    assign w_fill = w_wbin_s - w_rbin_next;

    // Status uses the next-state pointer, so empty asserts on the same edge
    // that consumes the last entry.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin         <= '0;
            r_rgray        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_count        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rgray        <= w_rgray_next;
            r_empty        <= (w_rgray_next == rq2_wptr);
            r_almost_empty <= (w_fill <= c_AE_THRESH);
            r_count        <= w_fill;
            // Setting wins over a simultaneous clear so that no event is lost.
            if (rinc && r_empty) begin
                r_underflow <= 1'b1;
            end else if (rclr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign raddr         = r_rbin[ADDR_SIZE-1:0];
    assign rptr          = r_rgray;
    assign rempty        = r_empty;
    assign ralmost_empty = r_almost_empty;
    assign rcount        = r_count;
    assign runderflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rptr_empty_ctrl
// Description : Self-checking bench for rptr_empty_ctrl (ADDR_SIZE=4,
//               AE_THRESH=2). The bench keeps its own read/write occupancy
//               model. Expected outputs are queued when each cycle is driven
//               and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic       rclr_err;
    logic [4:0] rq2_wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rcount;
    logic       runderflow;

    rptr_empty_ctrl #(.ADDR_SIZE(4), .AE_THRESH(2)) u_dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .rclr_err      (rclr_err),
        .rq2_wptr      (rq2_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rcount        (rcount),
        .runderflow    (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] raddr;
        logic [4:0] rptr;
        logic       empty;
        logic       ae;
        logic [4:0] cnt;
        logic       under;
    } exp_t;

    exp_t exp_q[$];

    // Bench model state: read count, registered empty view, sticky error.
    logic [4:0] m_rbin;
    logic       m_empty;
    logic       m_under;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, req, $time);
        end
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_rbin  = 5'd0;
        m_empty = 1'b1;
        m_under = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rempty"}, 32'(rempty), 32'd1);
        chk({tag, "_ae"},     32'(ralmost_empty), 32'd1);
        chk({tag, "_rptr"},   32'(rptr), 32'd0);
        chk({tag, "_raddr"},  32'(raddr), 32'd0);
        chk({tag, "_rcount"}, 32'(rcount), 32'd0);
        chk({tag, "_under"},  32'(runderflow), 32'd0);
    endtask

    // One clock cycle: wb is the binary write count the bench claims.
    task automatic step(input logic inc, input logic clr, input logic [4:0] wb);
        exp_t       e;
        exp_t       g;
        logic       rd;
        logic [4:0] nb;
        logic [4:0] fill;
        rinc     = inc;
        rclr_err = clr;
        rq2_wptr = to_gray(wb);
        rd   = inc && !m_empty;
        nb   = m_rbin + (rd ? 5'd1 : 5'd0);
        fill = wb - nb;
        e.raddr = nb[3:0];
        e.rptr  = to_gray(nb);
        e.empty = (fill == 5'd0);
        e.ae    = (fill <= 5'd2);
        e.cnt   = fill;
        e.under = (inc && m_empty) ? 1'b1 : (clr ? 1'b0 : m_under);
        exp_q.push_back(e);
        m_rbin  = nb;
        m_empty = e.empty;
        m_under = e.under;
        @(posedge rclk);
        #1;
        g = exp_q.pop_front();
        chk("raddr",  32'(raddr), 32'(g.raddr));
        chk("rptr",   32'(rptr), 32'(g.rptr));
        chk("rempty", 32'(rempty), 32'(g.empty));
        chk("ae",     32'(ralmost_empty), 32'(g.ae));
        chk("rcount", 32'(rcount), 32'(g.cnt));
        chk("under",  32'(runderflow), 32'(g.under));
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        #2;
        rrst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [4:0] w;
        rinc     = 1'b0;
        rclr_err = 1'b0;
        rq2_wptr = 5'd0;
        rrst_n   = 1'b0;
        model_reset();

        // 1. Reset values
        repeat (2) @(posedge rclk);
        #1;
        check_reset_vals("rst");
        rrst_n = 1'b1;

        // 2. Basic drain
        step(1'b0, 1'b0, 5'd3);
        chk("p2_rcount3", 32'(rcount), 32'd3);
        repeat (3) step(1'b1, 1'b0, 5'd3);
        chk("p2_rptr", 32'(rptr), 32'b00010);
        chk("p2_empty", 32'(rempty), 32'd1);

        // 3. Underflow set, clear, set-over-clear, clear
        repeat (2) step(1'b1, 1'b0, 5'd3);
        chk("p3_rptr_hold", 32'(rptr), 32'b00010);
        step(1'b0, 1'b1, 5'd3);
        step(1'b1, 1'b1, 5'd3);
        chk("p3_set_prio", 32'(runderflow), 32'd1);
        step(1'b0, 1'b1, 5'd3);

        // 4. Wrap
        do_reset();
        step(1'b0, 1'b0, 5'd16);
        chk("p4_full_cnt", 32'(rcount), 32'd16);
        repeat (16) step(1'b1, 1'b0, 5'd16);
        chk("p4_rptr", 32'(rptr), 32'b11000);
        chk("p4_raddr", 32'(raddr), 32'd0);
        step(1'b0, 1'b0, 5'd20);
        chk("p4_cnt4", 32'(rcount), 32'd4);

        // 5. Threshold boundary: 4 -> 3 -> 2, then drain
        step(1'b1, 1'b0, 5'd20);
        chk("p5_ae_at3", 32'(ralmost_empty), 32'd0);
        step(1'b1, 1'b0, 5'd20);
        chk("p5_ae_at2", 32'(ralmost_empty), 32'd1);
        repeat (2) step(1'b1, 1'b0, 5'd20);

        // Random traffic; the write pointer advances at most one step per cycle
        w = 5'd20;
        for (int i = 0; i < 60; i++) begin
            logic [4:0] fill;
            fill = w - m_rbin;
            if (fill < 5'd16 && ($urandom_range(0, 1) == 1)) w = w + 5'd1;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), w);
        end

        // 6. Mid-operation asynchronous reset
        do_reset();
        step(1'b0, 1'b0, 5'd5);
        chk("p6_cnt5", 32'(rcount), 32'd5);
        rinc = 1'b1;
        @(negedge rclk);
        rrst_n = 1'b0;
        #1;
        check_reset_vals("p6_async");
        #1;
        rrst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 5'd5);
        chk("p6_after_cnt", 32'(rcount), 32'd5);
        chk("p6_after_empty", 32'(rempty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
